adc_capture: RTL and testbench
==============================

Name: adc_capture

Overview:
- Receive-side counterpart of the DAC output path. Registers the two 14-bit offset-binary ADC channels (A/B) and their out-of-range flags, then converts each to two's complement.
- Decimates each channel by 2^DECIM_LOG2 using a boxcar average.
- Delivers paired samples on a valid/ready stream to downstream demodulator logic.
- Tracks samples dropped because the stream was stalled.

Parameters:
- N, 14, ADC sample width in bits.
- DECIM_LOG2, 2, log2 of the decimation/averaging length. Legal range 0..6; 0 means no decimation.
- CNT_W, 16, width of the overrun counter.

Ports:
- CLOCK_50  in  1  system clock; ADC sampling clock domain.
- reset_n  in  1  asynchronous active-low reset.
- adc_da  in  N  channel A raw sample, unsigned offset-binary.
- adc_db  in  N  channel B raw sample, unsigned offset-binary.
- adc_otr_a  in  1  channel A out-of-range flag.
- adc_otr_b  in  1  channel B out-of-range flag.
- capture_en  in  1  qualifies the current input sample.
- clear  in  1  synchronous flush.
- out_a  out  N  signed averaged sample, channel A.
- out_b  out  N  signed averaged sample, channel B.
- out_otr_a  out  1  set if any sample in the block had OTR on channel A.
- out_otr_b  out  1  same, channel B.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- overrun_cnt  out  CNT_W  saturating count of dropped output samples.

Behaviour:
- Reset (reset_n low, async): clears all pipeline registers, accumulators, phase counter, FIFO and overrun_cnt. Outputs go to out_valid=0, out_a/out_b=0, out_otr_*=0, overrun_cnt=0.
- clear (sync): same effect as reset at the next edge. clear has priority over every other input.
- Stage 1 (input register): captures adc_d*, adc_otr_* and capture_en every edge.
- Stage 2 (convert):
  - Normal: signed value = {~msb, lower N-1 bits}.
  - If OTR is set: saturate instead. Raw msb=1 gives +(2^(N-1)-1); raw msb=0 gives -2^(N-1).
- Stage 2 (accumulate):
  - Runs only when the registered capture_en is 1.
  - Accumulator is signed, N+DECIM_LOG2 bits, so it cannot overflow.
  - phase counter runs 0..2^DECIM_LOG2-1; its width is max(1,DECIM_LOG2).
  - The OTR sticky bit for the block is the OR over the block.
- End of block (phase at its last value with a qualified sample):
  - result = (acc + sample) >>> DECIM_LOG2, arithmetic shift, truncation toward minus infinity. The result fits in N bits.
  - The result and OTR bits are pushed to the FIFO; the accumulator, sticky bits and phase reset to 0 in the same cycle.
- capture_en low: accumulator and phase hold. A block interrupted by gaps resumes where it stopped.
- Latency: with DECIM_LOG2=0 and an empty FIFO, a sample present at edge k gives out_valid=1 with its data after edge k+3. In general, the last sample of a block shows up 3 edges later.
- Output FIFO: 2 entries, first-word fall-through.
  - out_valid = (FIFO not empty).
  - A transfer occurs when out_valid and out_ready are both 1 on an edge.
  - out_a/out_b/out_otr_* hold stable while out_valid=1 and out_ready=0.
- Boundary cases:
  - Push while full with no pop: the new sample is dropped, stored entries are untouched, and overrun_cnt increments. It saturates at all-ones.
  - Push and pop in the same cycle while full: both succeed and no overrun is counted.
  - Push and pop in the same cycle while empty: only the push takes effect, since out_valid was 0.
- No other state machine; control consists of the phase counter plus the FIFO occupancy count (0..2).

Decomposition:
- Shared package adc_pkg:
  - Localparam ADC_W=14.
  - Saturation constants SAT_POS/SAT_NEG.
  - Function ob_to_tc (offset binary to two's complement, with OTR saturation), reused by the DAC-side converter tests.
- Sub-module adc_skid_fifo:
  - 2-entry FWFT FIFO, parameterised on data width.
  - Provides push/full/pop/empty, an occupancy output, and simultaneous push/pop while full.
- Phase counter and accumulators stay in adc_capture.

Test Plan:
- DECIM_LOG2=0, capture_en=1, out_ready=1; adc_da = 14'h2000, 14'h0000, 14'h3FFF on consecutive edges -> out_a = 0, -8192, +8191. Each appears 3 edges after its input edge, with out_valid high for 1 cycle each.
- DECIM_LOG2=2; adc_da = 8292, 8294, 8296, 8298 (signed 100..106); adc_db = 8191, 8191, 8190, 8190 (signed -1, -1, -2, -2) -> one output with out_a=103, out_b=-2 (sum -6 >>> 2). out_valid pulses once per 4 inputs.
- DECIM_LOG2=0; adc_otr_a=1 with adc_da=14'h3FF0, then adc_otr_a=1 with adc_da=14'h0010 -> out_a=+8191 then -8192, with out_otr_a=1 on both.
- DECIM_LOG2=0, out_ready=0; 5 consecutive samples 1..5 -> out_valid=1 holding sample 1, overrun_cnt=3. Then out_ready=1 -> samples 1, 2 delivered in order, then out_valid=0.
- DECIM_LOG2=2; 2 samples, then capture_en=0 for 5 cycles, then 2 more -> single correct average, no output during the gap. Repeat with reset_n pulsed low after 2 samples -> all outputs 0 at once, and the next 4 samples form a fresh block.
- Full FIFO with out_ready=1 and a new block completing on the same edge -> no overrun count; 2 entries remain with correct order.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC constants and the offset-binary to two's complement converter.
package adc_pkg;

    localparam int ADC_W = 14;

    localparam logic signed [ADC_W-1:0] SAT_POS = {1'b0, {(ADC_W-1){1'b1}}};
    localparam logic signed [ADC_W-1:0] SAT_NEG = {1'b1, {(ADC_W-1){1'b0}}};

    // Out-of-range samples saturate toward the rail the raw msb points at.
    function automatic logic signed [ADC_W-1:0] ob_to_tc(
        input logic [ADC_W-1:0] raw,
        input logic             otr
    );
        if (otr)
            return raw[ADC_W-1] ? SAT_POS : SAT_NEG;
        return {~raw[ADC_W-1], raw[ADC_W-2:0]};
    endfunction

endpackage

// File: rtl/adc_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; accepts push+pop while full.
module adc_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign empty   = (cnt == 2'd0);
    assign full    = (cnt == 2'd2);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (clr) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Dual-channel ADC capture: register, convert, boxcar-decimate, stream out.
module adc_capture
    import adc_pkg::*;
#(
    parameter int N          = ADC_W,
    parameter int DECIM_LOG2 = 2,
    parameter int CNT_W      = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic [N-1:0]     adc_da,
    input  logic [N-1:0]     adc_db,
    input  logic             adc_otr_a,
    input  logic             adc_otr_b,
    input  logic             capture_en,
    input  logic             clear,
    output logic [N-1:0]     out_a,
    output logic [N-1:0]     out_b,
    output logic             out_otr_a,
    output logic             out_otr_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] overrun_cnt
);

    localparam int ACC_W = N + DECIM_LOG2;
    localparam int PH_W  = (DECIM_LOG2 < 1) ? 1 : DECIM_LOG2;
    localparam int FW    = 2 * N + 2;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);

    logic [N-1:0]            s1_da, s1_db;
    logic                    s1_otr_a, s1_otr_b, s1_en;
    logic signed [N-1:0]     s2_a, s2_b;
    logic                    s2_otr_a, s2_otr_b, s2_en;
    logic signed [ACC_W-1:0] acc_a, acc_b;
    logic signed [ACC_W-1:0] sum_a, sum_b;
    logic                    sticky_a, sticky_b;
    logic                    stick_a, stick_b;
    logic [PH_W-1:0]         phase;
    logic                    blk_end;
    logic [N-1:0]            avg_a, avg_b;
    logic                    push_vld;
    logic [FW-1:0]           push_data;
    logic [FW-1:0]           fifo_dout;
    logic                    fifo_full, fifo_empty;
    logic [1:0]              fifo_count;
    logic                    pop_ok, drop;

    assign sum_a   = acc_a + ACC_W'(s2_a);
    assign sum_b   = acc_b + ACC_W'(s2_b);
    assign avg_a   = N'(sum_a >>> DECIM_LOG2);
    assign avg_b   = N'(sum_b >>> DECIM_LOG2);
    assign stick_a = sticky_a | s2_otr_a;
    assign stick_b = sticky_b | s2_otr_b;
    assign blk_end = s2_en && (phase == PH_LAST);

    // A full FIFO only loses the new block if nothing leaves this edge.
    assign pop_ok  = out_ready && (fifo_count != 2'd0);
    assign drop    = push_vld && fifo_full && !pop_ok;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_da       <= '0;
            s1_db       <= '0;
            s1_otr_a    <= 1'b0;
            s1_otr_b    <= 1'b0;
            s1_en       <= 1'b0;
            s2_a        <= '0;
            s2_b        <= '0;
            s2_otr_a    <= 1'b0;
            s2_otr_b    <= 1'b0;
            s2_en       <= 1'b0;
            acc_a       <= '0;
            acc_b       <= '0;
            sticky_a    <= 1'b0;
            sticky_b    <= 1'b0;
            phase       <= '0;
            push_vld    <= 1'b0;
            push_data   <= '0;
            overrun_cnt <= '0;
        end else if (clear) begin
            s1_da       <= '0;
            s1_db       <= '0;
            s1_otr_a    <= 1'b0;
            s1_otr_b    <= 1'b0;
            s1_en       <= 1'b0;
            s2_a        <= '0;
            s2_b        <= '0;
            s2_otr_a    <= 1'b0;
            s2_otr_b    <= 1'b0;
            s2_en       <= 1'b0;
            acc_a       <= '0;
            acc_b       <= '0;
            sticky_a    <= 1'b0;
            sticky_b    <= 1'b0;
            phase       <= '0;
            push_vld    <= 1'b0;
            push_data   <= '0;
            overrun_cnt <= '0;
        end else begin
            s1_da    <= adc_da;
            s1_db    <= adc_db;
            s1_otr_a <= adc_otr_a;
            s1_otr_b <= adc_otr_b;
            s1_en    <= capture_en;
            s2_a     <= ob_to_tc(s1_da, s1_otr_a);
            s2_b     <= ob_to_tc(s1_db, s1_otr_b);
            s2_otr_a <= s1_otr_a;
            s2_otr_b <= s1_otr_b;
            s2_en    <= s1_en;
            push_vld <= blk_end;
            if (blk_end) begin
                push_data <= {stick_a, stick_b, avg_a, avg_b};
                acc_a     <= '0;
                acc_b     <= '0;
                sticky_a  <= 1'b0;
                sticky_b  <= 1'b0;
                phase     <= '0;
            end else if (s2_en) begin
                acc_a    <= sum_a;
                acc_b    <= sum_b;
                sticky_a <= stick_a;
                sticky_b <= stick_b;
                phase    <= phase + 1'b1;
            end
            if (drop && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

    adc_skid_fifo #(
        .W(FW)
    ) u_fifo (
        .clk  (CLOCK_50),
        .rst_n(reset_n),
        .clr  (clear),
        .push (push_vld),
        .din  (push_data),
        .full (fifo_full),
        .pop  (out_ready),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign {out_otr_a, out_otr_b, out_a, out_b} = fifo_dout;
    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture with DECIM_LOG2=0 and DECIM_LOG2=2 instances.
module tb_adc_capture;

    localparam int N = 14;
    localparam int W = 16;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    logic clear;

    always #10 CLOCK_50 = ~CLOCK_50;

    logic [N-1:0] d0_da, d0_db, d0_out_a, d0_out_b;
    logic         d0_otr_a, d0_otr_b, d0_en, d0_ready;
    logic         d0_out_otr_a, d0_out_otr_b, d0_out_valid;
    logic [W-1:0] d0_ovr;

    logic [N-1:0] d2_da, d2_db, d2_out_a, d2_out_b;
    logic         d2_otr_a, d2_otr_b, d2_en, d2_ready;
    logic         d2_out_otr_a, d2_out_otr_b, d2_out_valid;
    logic [W-1:0] d2_ovr;

    adc_capture #(.N(N), .DECIM_LOG2(0), .CNT_W(W)) dut0 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .adc_da(d0_da), .adc_db(d0_db),
        .adc_otr_a(d0_otr_a), .adc_otr_b(d0_otr_b),
        .capture_en(d0_en), .clear(clear),
        .out_a(d0_out_a), .out_b(d0_out_b),
        .out_otr_a(d0_out_otr_a), .out_otr_b(d0_out_otr_b),
        .out_valid(d0_out_valid), .out_ready(d0_ready),
        .overrun_cnt(d0_ovr)
    );

    adc_capture #(.N(N), .DECIM_LOG2(2), .CNT_W(W)) dut2 (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n),
        .adc_da(d2_da), .adc_db(d2_db),
        .adc_otr_a(d2_otr_a), .adc_otr_b(d2_otr_b),
        .capture_en(d2_en), .clear(clear),
        .out_a(d2_out_a), .out_b(d2_out_b),
        .out_otr_a(d2_out_otr_a), .out_otr_b(d2_out_otr_b),
        .out_valid(d2_out_valid), .out_ready(d2_ready),
        .overrun_cnt(d2_ovr)
    );

    int checks = 0;
    int errors = 0;
    logic [2*N+1:0] q0[$];
    logic [2*N+1:0] q2[$];

    function automatic logic [2*N+1:0] mk(input int a, input int b,
                                          input bit oa, input bit ob_);
        logic [N-1:0] ta, tb;
        ta = N'(a);
        tb = N'(b);
        return {oa, ob_, ta, tb};
    endfunction

    function automatic logic [N-1:0] ob(input int s);
        return N'(s + 8192);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Monitors pop the expected entry on every accepted transfer.
    always @(negedge CLOCK_50) begin : mon0
        logic [2*N+1:0] e;
        if (reset_n && !clear && d0_out_valid && d0_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL d0_unexpected: got a=%0d b=%0d, none expected",
                         $signed(d0_out_a), $signed(d0_out_b));
            end else begin
                e = q0.pop_front();
                if ({d0_out_otr_a, d0_out_otr_b, d0_out_a, d0_out_b} !== e) begin
                    errors++;
                    $display("FAIL d0_data: got a=%0d b=%0d otr=%b%b expected a=%0d b=%0d otr=%b%b",
                             $signed(d0_out_a), $signed(d0_out_b), d0_out_otr_a, d0_out_otr_b,
                             $signed(e[2*N-1:N]), $signed(e[N-1:0]), e[2*N+1], e[2*N]);
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin : mon2
        logic [2*N+1:0] e;
        if (reset_n && !clear && d2_out_valid && d2_ready) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL d2_unexpected: got a=%0d b=%0d, none expected",
                         $signed(d2_out_a), $signed(d2_out_b));
            end else begin
                e = q2.pop_front();
                if ({d2_out_otr_a, d2_out_otr_b, d2_out_a, d2_out_b} !== e) begin
                    errors++;
                    $display("FAIL d2_data: got a=%0d b=%0d otr=%b%b expected a=%0d b=%0d otr=%b%b",
                             $signed(d2_out_a), $signed(d2_out_b), d2_out_otr_a, d2_out_otr_b,
                             $signed(e[2*N-1:N]), $signed(e[N-1:0]), e[2*N+1], e[2*N]);
                end
            end
        end
    end

    int a4[4];
    int b4[4];

    initial begin
        reset_n  = 1'b0;
        clear    = 1'b0;
        d0_da    = ob(0); d0_db = ob(0);
        d0_otr_a = 1'b0;  d0_otr_b = 1'b0;
        d0_en    = 1'b0;  d0_ready = 1'b1;
        d2_da    = ob(0); d2_db = ob(0);
        d2_otr_a = 1'b0;  d2_otr_b = 1'b0;
        d2_en    = 1'b0;  d2_ready = 1'b1;
        tick(2);
        chk("rst_d0_valid", int'(d0_out_valid), 0);
        chk("rst_d0_a", int'($signed(d0_out_a)), 0);
        chk("rst_d0_ovr", int'(d0_ovr), 0);
        chk("rst_d2_valid", int'(d2_out_valid), 0);
        chk("rst_d2_b", int'($signed(d2_out_b)), 0);
        reset_n = 1'b1;
        tick(2);

        // Pass-through with latency of three edges.
        q0.push_back(mk(0, 0, 0, 0));
        q0.push_back(mk(-8192, 0, 0, 0));
        q0.push_back(mk(8191, 0, 0, 0));
        d0_en = 1'b1;
        d0_da = 14'h2000; tick();
        d0_da = 14'h0000; tick();
        d0_da = 14'h3FFF; tick();
        d0_en = 1'b0; d0_da = ob(0);
        chk("t1_lat_k2_valid", int'(d0_out_valid), 0);
        tick();
        chk("t1_lat_k3_valid", int'(d0_out_valid), 1);
        chk("t1_lat_k3_a", int'($signed(d0_out_a)), 0);
        tick();
        chk("t1_k4_a", int'($signed(d0_out_a)), -8192);
        tick();
        chk("t1_k5_a", int'($signed(d0_out_a)), 8191);
        tick();
        chk("t1_k6_valid", int'(d0_out_valid), 0);

        // Out-of-range saturation.
        q0.push_back(mk(8191, 0, 1, 0));
        q0.push_back(mk(-8192, 0, 1, 0));
        d0_en = 1'b1; d0_otr_a = 1'b1;
        d0_da = 14'h3FF0; tick();
        d0_da = 14'h0010; tick();
        d0_en = 1'b0; d0_otr_a = 1'b0; d0_da = ob(0);
        tick(6);
        chk("t3_q0_drained", q0.size(), 0);

        // Four-sample boxcar average.
        q2.push_back(mk(103, -2, 0, 0));
        a4 = '{8292, 8294, 8296, 8298};
        b4 = '{8191, 8191, 8190, 8190};
        d2_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d2_da = N'(a4[i]); d2_db = N'(b4[i]);
            tick();
        end
        d2_en = 1'b0; d2_da = ob(0); d2_db = ob(0);
        tick(6);
        chk("t2_q2_drained", q2.size(), 0);

        // Stalled stream: two stored, three dropped.
        d0_ready = 1'b0;
        q0.push_back(mk(1, 0, 0, 0));
        q0.push_back(mk(2, 0, 0, 0));
        d0_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            d0_da = ob(i);
            tick();
        end
        d0_en = 1'b0; d0_da = ob(0);
        tick(5);
        chk("t4_hold_valid", int'(d0_out_valid), 1);
        chk("t4_hold_a", int'($signed(d0_out_a)), 1);
        chk("t4_overrun", int'(d0_ovr), 3);
        d0_ready = 1'b1;
        tick(3);
        chk("t4_after_valid", int'(d0_out_valid), 0);
        chk("t4_q0_drained", q0.size(), 0);

        // Full FIFO: push and pop on the same edge.
        d0_ready = 1'b0;
        q0.push_back(mk(11, 0, 0, 0));
        q0.push_back(mk(12, 0, 0, 0));
        q0.push_back(mk(13, 0, 0, 0));
        d0_en = 1'b1;
        d0_da = ob(11); tick();
        d0_da = ob(12); tick();
        d0_en = 1'b0; d0_da = ob(0);
        tick(4);
        chk("t6_full_a", int'($signed(d0_out_a)), 11);
        d0_en = 1'b1; d0_da = ob(13); tick();
        d0_en = 1'b0; d0_da = ob(0);
        tick(2);
        d0_ready = 1'b1;
        tick();
        d0_ready = 1'b0;
        chk("t6_no_overrun", int'(d0_ovr), 3);
        chk("t6_valid", int'(d0_out_valid), 1);
        chk("t6_head_a", int'($signed(d0_out_a)), 12);
        d0_ready = 1'b1;
        tick(3);
        chk("t6_q0_drained", q0.size(), 0);
        chk("t6_after_valid", int'(d0_out_valid), 0);

        // Block interrupted by a capture_en gap.
        q2.push_back(mk(25, -5, 0, 0));
        a4 = '{10, 20, 30, 41};
        b4 = '{-3, -4, -5, -6};
        for (int i = 0; i < 4; i++) begin
            d2_en = 1'b1;
            d2_da = ob(a4[i]); d2_db = ob(b4[i]);
            tick();
            if (i == 1) begin
                d2_en = 1'b0;
                for (int g = 0; g < 5; g++) begin
                    tick();
                    chk("t5_gap_valid", int'(d2_out_valid), 0);
                end
            end
        end
        d2_en = 1'b0; d2_da = ob(0); d2_db = ob(0);
        tick(6);
        chk("t5_q2_drained", q2.size(), 0);

        // Reset mid-block discards the partial block.
        d2_en = 1'b1;
        d2_da = ob(3000); d2_db = ob(3000); tick();
        d2_da = ob(3000); d2_db = ob(3000); tick();
        d2_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t5r_d0_ovr", int'(d0_ovr), 0);
        chk("t5r_d0_a", int'($signed(d0_out_a)), 0);
        chk("t5r_d2_valid", int'(d2_out_valid), 0);
        chk("t5r_d2_a", int'($signed(d2_out_a)), 0);
        tick();
        reset_n = 1'b1;
        tick();
        q2.push_back(mk(2, -1, 0, 0));
        d2_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d2_da = ob(i); d2_db = ob(-1);
            tick();
        end
        d2_en = 1'b0; d2_da = ob(0); d2_db = ob(0);
        tick(6);
        chk("t5r_q2_drained", q2.size(), 0);

        // Synchronous clear beats a concurrent qualified sample.
        d0_ready = 1'b0;
        d0_en = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            d0_da = ob(i);
            tick();
        end
        d0_en = 1'b0; d0_da = ob(0);
        tick(5);
        chk("clr_pre_ovr", int'(d0_ovr), 1);
        chk("clr_pre_a", int'($signed(d0_out_a)), 7);
        clear = 1'b1;
        d0_en = 1'b1; d0_da = ob(5);
        tick();
        clear = 1'b0;
        d0_en = 1'b0; d0_da = ob(0);
        chk("clr_valid", int'(d0_out_valid), 0);
        chk("clr_ovr", int'(d0_ovr), 0);
        chk("clr_a", int'($signed(d0_out_a)), 0);
        d0_ready = 1'b1;
        tick(5);
        chk("clr_after_valid", int'(d0_out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
